hmemc_axi_traffic_chk: RTL
==========================

# hmemc_axi_traffic_chk

Traffic generator and checker that sits directly upstream of the HMEMC AXI user port inside the DDR test top. After `ddr_init_done`, it writes deterministic burst patterns across a configurable address window. It then reads the window back and compares every beat, reporting a sticky error flag and counters for board LEDs and simulation. It loops forever, incrementing a pass counter that also perturbs the pattern seed.

## Interface
- `DATA_W`, 128, AXI data width; multiple of 32.
- `ADDR_W`, 28, AXI byte-address width.
- `BURST_LEN`, 16, beats per burst (1..256); `axi_awlen`/`axi_arlen` = `BURST_LEN-1`.
- `NUM_BURSTS`, 64, bursts per write or read phase (≥1).
- `BASE_ADDR`, 0, first burst byte address.

Ports:
- `core_clk` in 1: sole clock (HMEMC user clock).
- `core_rst` in 1: synchronous, active-high reset.
- `ddr_init_done` in 1: controller ready; sampled only in IDLE.
- `axi_awaddr` out ADDR_W; `axi_awlen` out 8; `axi_awvalid` out 1; `axi_awready` in 1.
- `axi_wdata` out DATA_W; `axi_wstrb` out DATA_W/8 (all ones); `axi_wlast` out 1; `axi_wvalid` out 1; `axi_wready` in 1.
- `axi_araddr` out ADDR_W; `axi_arlen` out 8; `axi_arvalid` out 1; `axi_arready` in 1.
- `axi_rdata` in DATA_W; `axi_rlast` in 1; `axi_rvalid` in 1 (always accepted; no rready).
- `err_flag` out 1: sticky, set on first mismatch.
- `err_cnt` out 16: mismatching beats, saturates at 0xFFFF.
- `pass_cnt` out 16: completed write+read passes, wraps.
- `test_busy` out 1: high in any state other than IDLE.

## Operation
- Burst address: `A(b) = BASE_ADDR + b*BURST_LEN*DATA_W/8`, with b = 0..NUM_BURSTS-1, truncated to ADDR_W.
- Pattern word `P(b,k,i) = A(b)[31:0] + k + i + {pass_cnt,16'h0}` (mod 2^32), where k is the beat index and i is the 32-bit lane index; lane i occupies `wdata[32i+31:32i]`.
- States:
  - IDLE: wait for `ddr_init_done`=1, then go to WA with b=0.
  - WA: `awvalid`=1 with `A(b)`. On `awready`, go to WD.
  - WD: `wvalid`=1, k=0..BURST_LEN-1; `wlast`=1 when k=BURST_LEN-1. A beat advances only on `wvalid&wready`. After the last beat: if b<NUM_BURSTS-1, b++ and go to WA; otherwise b=0 and go to RA.
  - RA: `arvalid`=1 with `A(b)`. On `arready`, go to RD.
  - RD: accept beats on `rvalid` and compare `rdata` to `P(b,k,*)`.
    - A mismatch of any lane is one error for that beat.
    - `rlast` asserted at the wrong k is also one error for that beat (counted once together with a data error).
    - The burst ends on the beat with k=BURST_LEN-1, regardless of `rlast`.
    - After the burst: if b<NUM_BURSTS-1, b++ and go to RA; otherwise go to NX.
  - NX: one cycle; `pass_cnt`++, b=0, go to WA. `ddr_init_done` is not re-checked.
- At most one outstanding address; the next address is issued only after its data phase completes.
- The generator drives `axi_wvalid` only in WD. It never deasserts a valid before its ready.
- Reset values, all outputs 0: valids, `wlast`, addresses, lens driven to `BURST_LEN-1` constant, `wstrb` all ones, `err_flag`=0, `err_cnt`=0, `pass_cnt`=0, `test_busy`=0, state IDLE.
- Reset mid-burst aborts immediately; the next cycle shows reset values. No recovery handshake is needed; the integrator resets the controller alongside.

## Timing
- Entering WA/RA asserts the valid in that same registered cycle; the address is stable while valid.
- `wdata`/`wlast` are registered; the next beat appears the cycle after a handshake.
- Compare pipeline: the `rdata` beat is registered at cycle N. `err_flag`/`err_cnt` update at N+1, so 1-cycle latency.
- IDLE→WA takes 1 cycle after `ddr_init_done` is sampled high.
- WD→WA, RD→RA and NX→WA each take 1 cycle.
- `pass_cnt` increments in the NX cycle and is visible on the following cycle.
- Simultaneous error and saturation: `err_cnt` holds at 0xFFFF while `err_flag` stays 1.

## Test plan
- Reset, `ddr_init_done`=0 for 100 cycles -> all outputs at reset values, `test_busy`=0, no valids asserted.
- Zero-wait-state slave model (ready tied 1, read returns written data), `BURST_LEN`=4, `NUM_BURSTS`=2 -> addresses 0x0, 0x40, then reads 0x0, 0x40. Beat 0 of burst 0 lane 1 = 0x00000001. `pass_cnt`=1 after pass, `err_flag`=0.
- Random backpressure on `awready`/`wready`/`arready` (50%) -> valids and data hold stable until accepted. Exactly BURST_LEN·NUM_BURSTS write beats. `err_flag`=0.
- Slave flips `rdata` bit 0 on beat 2 of burst 1 -> `err_flag`=1 one cycle after that beat, `err_cnt`=1, test continues to NX.
- Slave asserts `rlast` on beat 1 of a 4-beat burst with correct data -> `err_cnt`=1, burst still consumes 4 beats.
- Assert `core_rst` mid-WD -> next cycle `axi_wvalid`=0, state IDLE, counters 0. Restart with `ddr_init_done`=1 -> first address is `BASE_ADDR`.

Source files
------------

// File: rtl/hmemc_axi_traffic_chk.sv
// rtl/hmemc_axi_traffic_chk.sv - AXI write/read-back traffic generator and checker for DDR bring-up
// Writes a pass-seeded pattern over a burst window, reads it back, compares every beat, and loops forever.
module hmemc_axi_traffic_chk #(
    parameter int                DATA_W     = 128,
    parameter int                ADDR_W     = 28,
    parameter int                BURST_LEN  = 16,
    parameter int                NUM_BURSTS = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                  core_clk,
    input  logic                  core_rst,
    input  logic                  ddr_init_done,

    output logic [ADDR_W-1:0]     axi_awaddr,
    output logic [7:0]            axi_awlen,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,

    output logic [DATA_W-1:0]     axi_wdata,
    output logic [DATA_W/8-1:0]   axi_wstrb,
    output logic                  axi_wlast,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,

    output logic [ADDR_W-1:0]     axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,

    input  logic [DATA_W-1:0]     axi_rdata,
    input  logic                  axi_rlast,
    input  logic                  axi_rvalid,

    output logic                  err_flag,
    output logic [15:0]           err_cnt,
    output logic [15:0]           pass_cnt,
    output logic                  test_busy
);

    localparam int LANES       = DATA_W / 32;
    localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;
    localparam int K_W         = (BURST_LEN  > 1) ? $clog2(BURST_LEN)  : 1;
    localparam int B_W         = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(BURST_LEN - 1);
    localparam logic [B_W-1:0] B_LAST = B_W'(NUM_BURSTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WA,
        S_WD,
        S_RA,
        S_RD,
        S_NX
    } state_t;

    state_t             state;
    logic [B_W-1:0]     burst_idx;
    logic [K_W-1:0]     beat_idx;
    logic [B_W-1:0]     next_b;
    logic [K_W-1:0]     next_k;

    // Second stage of the read compare: captured beat, its expected seed and rlast verdict
    logic               cmp_valid;
    logic [DATA_W-1:0]  cmp_data;
    logic [31:0]        cmp_seed;
    logic               cmp_rlast_bad;
    logic               cmp_err;

    function automatic logic [ADDR_W-1:0] burst_addr(input logic [B_W-1:0] b);
        return ADDR_W'(64'(BASE_ADDR) + 64'(b) * 64'(BURST_BYTES));
    endfunction

    function automatic logic [31:0] seed_of(input logic [B_W-1:0] b,
                                            input logic [K_W-1:0] k,
                                            input logic [15:0]    pass);
        return 32'(burst_addr(b)) + 32'(k) + {pass, 16'h0};
    endfunction

    function automatic logic [DATA_W-1:0] pattern(input logic [31:0] seed);
        logic [DATA_W-1:0] p;
        for (int i = 0; i < LANES; i++) begin
            p[32*i +: 32] = seed + 32'(i);
        end
        return p;
    endfunction

    assign next_b    = burst_idx + 1'b1;
    assign next_k    = beat_idx + 1'b1;
    assign axi_awlen = 8'(BURST_LEN - 1);
    assign axi_arlen = 8'(BURST_LEN - 1);
    assign axi_wstrb = '1;
    assign cmp_err   = cmp_valid && ((cmp_data != pattern(cmp_seed)) || cmp_rlast_bad);

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state         <= S_IDLE;
            burst_idx     <= '0;
            beat_idx      <= '0;
            axi_awaddr    <= '0;
            axi_awvalid   <= 1'b0;
            axi_wdata     <= '0;
            axi_wlast     <= 1'b0;
            axi_wvalid    <= 1'b0;
            axi_araddr    <= '0;
            axi_arvalid   <= 1'b0;
            err_flag      <= 1'b0;
            err_cnt       <= '0;
            pass_cnt      <= '0;
            test_busy     <= 1'b0;
            cmp_valid     <= 1'b0;
            cmp_data      <= '0;
            cmp_seed      <= '0;
            cmp_rlast_bad <= 1'b0;
        end else begin
            cmp_valid <= 1'b0;
            if (cmp_err) begin
                err_flag <= 1'b1;
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (ddr_init_done) begin
                        state       <= S_WA;
                        test_busy   <= 1'b1;
                        burst_idx   <= '0;
                        axi_awvalid <= 1'b1;
                        axi_awaddr  <= burst_addr('0);
                    end
                end

                S_WA: begin
                    if (axi_awready) begin
                        state       <= S_WD;
                        axi_awvalid <= 1'b0;
                        beat_idx    <= '0;
                        axi_wvalid  <= 1'b1;
                        axi_wdata   <= pattern(seed_of(burst_idx, '0, pass_cnt));
                        axi_wlast   <= (K_LAST == '0);
                    end
                end

                S_WD: begin
                    if (axi_wready) begin
                        if (beat_idx == K_LAST) begin
                            axi_wvalid <= 1'b0;
                            axi_wlast  <= 1'b0;
                            if (burst_idx == B_LAST) begin
                                state       <= S_RA;
                                burst_idx   <= '0;
                                axi_arvalid <= 1'b1;
                                axi_araddr  <= burst_addr('0);
                            end else begin
                                state       <= S_WA;
                                burst_idx   <= next_b;
                                axi_awvalid <= 1'b1;
                                axi_awaddr  <= burst_addr(next_b);
                            end
                        end else begin
                            beat_idx  <= next_k;
                            axi_wdata <= pattern(seed_of(burst_idx, next_k, pass_cnt));
                            axi_wlast <= (next_k == K_LAST);
                        end
                    end
                end

                S_RA: begin
                    if (axi_arready) begin
                        state       <= S_RD;
                        axi_arvalid <= 1'b0;
                        beat_idx    <= '0;
                    end
                end

                S_RD: begin
                    if (axi_rvalid) begin
                        cmp_valid     <= 1'b1;
                        cmp_data      <= axi_rdata;
                        cmp_seed      <= seed_of(burst_idx, beat_idx, pass_cnt);
                        cmp_rlast_bad <= (axi_rlast != (beat_idx == K_LAST));
                        // Burst length is fixed by the beat count; a misplaced rlast is only reported
                        if (beat_idx == K_LAST) begin
                            if (burst_idx == B_LAST) begin
                                state <= S_NX;
                            end else begin
                                state       <= S_RA;
                                burst_idx   <= next_b;
                                axi_arvalid <= 1'b1;
                                axi_araddr  <= burst_addr(next_b);
                            end
                        end else begin
                            beat_idx <= next_k;
                        end
                    end
                end

                S_NX: begin
                    state       <= S_WA;
                    pass_cnt    <= pass_cnt + 16'd1;
                    burst_idx   <= '0;
                    axi_awvalid <= 1'b1;
                    axi_awaddr  <= burst_addr('0);
                end

                default: begin
                    state     <= S_IDLE;
                    test_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
